// File: rtl/memory_module_256x16.sv
// 256x16 register-file RAM built from eight 32x16 banks: synchronous write, combinational read.
// Async active-high reset clears every word and blocks writes while asserted.
module memory_module_256x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic        addr0,
  input  logic        addr1,
  input  logic        addr2,
  input  logic        addr3,
  input  logic        addr4,
  input  logic        addr5,
  input  logic        addr6,
  input  logic        addr7,
  input  logic        WEn,
  output logic [15:0] qout
);

  logic [7:0]  addr;
  logic [2:0]  bank_sel;
  logic [4:0]  word_sel;
  logic [7:0]  bank_we;
  logic [15:0] bank_q [8];

  assign addr     = {addr7, addr6, addr5, addr4, addr3, addr2, addr1, addr0};
  assign bank_sel = addr[7:5];
  assign word_sel = addr[4:0];

  // One-hot bank write decode; all banks idle on a read-only cycle.
  always_comb begin
    bank_we = '0;
    if (WEn) begin
      bank_we[bank_sel] = 1'b1;
    end
  end

  for (genvar b = 0; b < 8; b++) begin : g_bank
    logic [15:0] mem [32];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          mem[i] <= 16'h0000;
        end
      end else if (bank_we[b]) begin
        mem[word_sel] <= data;
      end
    end

    assign bank_q[b] = mem[word_sel];
  end

  assign qout = bank_q[bank_sel];

endmodule

// File: tb/tb_memory_module_256x16.sv
// Directed bench for memory_module_256x16: reset sweep, writes, aliasing, gating, mid-op reset, boundaries.
module tb_memory_module_256x16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0000;
  logic [7:0]  a = 8'h00;
  logic        WEn = 1'b0;
  logic [15:0] qout;

  int nvec = 0;
  int nerr = 0;

  memory_module_256x16 dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .addr0(a[0]),
    .addr1(a[1]),
    .addr2(a[2]),
    .addr3(a[3]),
    .addr4(a[4]),
    .addr5(a[5]),
    .addr6(a[6]),
    .addr7(a[7]),
    .WEn  (WEn),
    .qout (qout)
  );

  always #10 clk = ~clk;

  // Drive one write at the next edge, leave WEn low afterwards.
  task automatic do_write(input logic [7:0] wa, input logic [15:0] wd);
    @(negedge clk);
    a = wa; data = wd; WEn = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (qout !== wd) begin
      $display("FAIL write_through a=%02h got=%04h exp=%04h", wa, qout, wd);
      nerr++;
    end
    @(negedge clk);
    WEn = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; WEn = 1'b0;
    #5;
    nvec++;
    if (qout !== 16'h0000) begin
      $display("FAIL reset_qout got=%04h exp=0000", qout);
      nerr++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      #1;
      nvec++;
      if (qout !== 16'h0000) begin
        $display("FAIL reset_sweep a=%02h got=%04h exp=0000", a, qout);
        nerr++;
      end
    end
  endtask

  task automatic test_write_sequence;
    logic [7:0]  ta [5];
    logic [15:0] td [5];
    ta = '{8'h00, 8'h01, 8'h02, 8'h84, 8'h48};
    td = '{16'h0000, 16'h0001, 16'h0010, 16'h0006, 16'h0012};
    for (int i = 0; i < 4; i++) do_write(ta[i], td[i]);
    // 0x48 held across two edges
    @(negedge clk);
    a = 8'h48; data = 16'h0012; WEn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    WEn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = ta[i];
      #2;
      nvec++;
      if (qout !== td[i]) begin
        $display("FAIL readback a=%02h got=%04h exp=%04h", ta[i], qout, td[i]);
        nerr++;
      end
    end
  endtask

  task automatic test_hold_last_wins;
    @(negedge clk);
    a = 8'h30; data = 16'h1111; WEn = 1'b1;
    @(posedge clk);
    #1;
    nvec++;
    if (qout !== 16'h1111) begin
      $display("FAIL hold_first got=%04h exp=1111", qout);
      nerr++;
    end
    @(negedge clk);
    data = 16'h2222;
    #1;
    nvec++;
    if (qout !== 16'h1111) begin
      $display("FAIL data_between_edges got=%04h exp=1111", qout);
      nerr++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    WEn = 1'b0;
    nvec++;
    if (qout !== 16'h2222) begin
      $display("FAIL hold_last got=%04h exp=2222", qout);
      nerr++;
    end
  endtask

  task automatic test_unwritten_alias;
    logic [7:0] ua [5];
    ua = '{8'h10, 8'h20, 8'h40, 8'h82, 8'h04};
    for (int i = 0; i < 5; i++) begin
      a = ua[i];
      #2;
      nvec++;
      if (qout !== 16'h0000) begin
        $display("FAIL unwritten a=%02h got=%04h exp=0000", ua[i], qout);
        nerr++;
      end
    end
  endtask

  task automatic test_we_gating;
    @(negedge clk);
    a = 8'h01; data = 16'hFFFF; WEn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if (qout !== 16'h0001) begin
      $display("FAIL we_gating got=%04h exp=0001", qout);
      nerr++;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 8'h48; WEn = 1'b0;
    #1;
    nvec++;
    if (qout !== 16'h0012) begin
      $display("FAIL pre_reset got=%04h exp=0012", qout);
      nerr++;
    end
    // write in flight to 0x84, reset lands before its edge
    a = 8'h84; data = 16'hBEEF; WEn = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    nvec++;
    if (qout !== 16'h0000) begin
      $display("FAIL reset_immediate got=%04h exp=0000", qout);
      nerr++;
    end
    @(posedge clk);
    #1;
    nvec++;
    if (qout !== 16'h0000) begin
      $display("FAIL reset_blocks_write got=%04h exp=0000", qout);
      nerr++;
    end
    @(negedge clk);
    WEn = 1'b0;
    rst = 1'b0;
    #1;
    nvec++;
    if (qout !== 16'h0000) begin
      $display("FAIL post_reset_84 got=%04h exp=0000", qout);
      nerr++;
    end
    a = 8'h48;
    #1;
    nvec++;
    if (qout !== 16'h0000) begin
      $display("FAIL post_reset_48 got=%04h exp=0000", qout);
      nerr++;
    end
    do_write(8'h84, 16'h0777);
  endtask

  task automatic test_boundary;
    do_write(8'hFF, 16'hA5A5);
    do_write(8'h00, 16'h5A5A);
    a = 8'hFF;
    #2;
    nvec++;
    if (qout !== 16'hA5A5) begin
      $display("FAIL boundary_ff got=%04h exp=A5A5", qout);
      nerr++;
    end
    a = 8'h00;
    #2;
    nvec++;
    if (qout !== 16'h5A5A) begin
      $display("FAIL boundary_00 got=%04h exp=5A5A", qout);
      nerr++;
    end
    a = 8'h84;
    #2;
    nvec++;
    if (qout !== 16'h0777) begin
      $display("FAIL boundary_84 got=%04h exp=0777", qout);
      nerr++;
    end
  endtask

  initial begin
    test_reset();
    test_write_sequence();
    test_unwritten_alias();
    test_we_gating();
    test_hold_last_wins();
    test_reset_mid();
    test_boundary();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
